// File: rtl/sub_serial.sv
// Digit-serial subtractor: d = (x - y - b_in) mod 2^WIDTH, DIGIT bits per clock, LSB slice first.
// Latency: accept on edge T, out_valid rises after edge T+N (N = WIDTH/DIGIT); one op per N+2 cycles.
// Backpressure: result, b_out, zero (and ovf) held in DONE until out_ready; no acceptance outside IDLE.
//
// Ports:
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (x, y, b_in sampled on accept)
//   out_valid / out_ready result handshake (d, b_out, zero, ovf)
//   d      difference (x - y - b_in) mod 2^WIDTH
//   b_out  1 iff x < y + b_in (unsigned)
//   zero   1 iff completed result is zero
//   ovf    two's-complement overflow, only when SUB_SIGNED_OVF_EN is defined
//
// Optional feature macro: SUB_SIGNED_OVF_EN (adds the ovf port and its logic).

module sub_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             b_out,
    output logic             zero
`ifdef SUB_SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = WIDTH / DIGIT;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    // Reject configurations where the operand does not split into whole slices.
    if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_cfg
        $error("sub_serial: WIDTH must be a positive multiple of DIGIT");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Operands and result are viewed as N slices so the slice counter
    // indexes them directly.
    typedef logic [N-1:0][DIGIT-1:0] slices_t;

    state_t          state_q;
    logic [KW-1:0]   k_q;
    slices_t         x_q;
    slices_t         y_q;
    slices_t         res_q;
    logic            borrow_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            b_out_q;
    logic            zero_q;
`ifdef SUB_SIGNED_OVF_EN
    logic            ovf_q;
    logic            ovf_d;
`endif

    logic [DIGIT:0]  diff_d;
    slices_t         res_d;

    // One slice of the subtraction on DIGIT+1 bits; the top bit of the
    // two's-complement difference is the borrow into the next slice.
    always_comb begin
        diff_d = {1'b0, x_q[k_q]} - {1'b0, y_q[k_q]} - {{DIGIT{1'b0}}, borrow_q};
        res_d  = res_q;
        res_d[k_q] = diff_d[DIGIT-1:0];
    end

`ifdef SUB_SIGNED_OVF_EN
    // Overflow when the operands differ in sign and the result sign
    // disagrees with the minuend; evaluated on the completed result.
    always_comb begin
        ovf_d = (x_q[N-1][DIGIT-1] != y_q[N-1][DIGIT-1]) &&
                (res_d[N-1][DIGIT-1] != x_q[N-1][DIGIT-1]);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            x_q         <= '0;
            y_q         <= '0;
            res_q       <= '0;
            borrow_q    <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            b_out_q     <= 1'b0;
            zero_q      <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
`ifdef SUB_SIGNED_OVF_EN
                    ovf_q <= 1'b0;
`endif
                    if (in_valid && in_ready_q) begin
                        x_q        <= x;
                        y_q        <= y;
                        borrow_q   <= b_in;
                        k_q        <= '0;
                        res_q      <= '0;
                        b_out_q    <= 1'b0;
                        zero_q     <= 1'b0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end else begin
                        // Also the path that raises in_ready on the first
                        // edge after reset release.
                        in_ready_q <= 1'b1;
                    end
                end

                RUN: begin
                    res_q    <= res_d;
                    borrow_q <= diff_d[DIGIT];
                    if (k_q == K_LAST) begin
                        b_out_q     <= diff_d[DIGIT];
                        zero_q      <= (res_d == '0);
`ifdef SUB_SIGNED_OVF_EN
                        ovf_q       <= ovf_d;
`endif
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end

                DONE: begin
                    // in_valid is deliberately not looked at here, so a
                    // collision with the output handshake never accepts.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
`ifdef SUB_SIGNED_OVF_EN
                        ovf_q       <= 1'b0;
`endif
                    end
                end

                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign d         = res_q;
    assign b_out     = b_out_q;
    assign zero      = zero_q;
`ifdef SUB_SIGNED_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule
